alu_sequencer: RTL and testbench

- Initiator side of the 32-bit ALU port (dataa/datab/4-bit Function/result).
- Accepts R-type operations (6-bit funct, 5-bit shamt, two 32-bit operands) over a valid/ready request channel.
- Decodes funct to the ALU Function code and drives the ALU. Multi-bit shifts are built from repeated single-bit ALU shift passes.
- Returns the result over a valid/ready response channel. Sits between the decode stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_sequencer_if.sv | 24 ++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response channels between the decode stage and the ALU sequencer.
// The producer/consumer side uses master; the sequencer uses slave.
interface alu_sequencer_if #(parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_funct;
  logic [4:0]        req_shamt;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_illegal;

  modport master (
    output req_valid, req_funct, req_shamt, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct, req_shamt, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// R-type op sequencer driving a 32-bit ALU; multi-bit shifts are repeated 1-bit ALU passes.
// Latency 1 (illegal/zero shift), 2 (arith/logic), n+1 (shift by n); one op in flight, req_ready only in IDLE.
module alu_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] alu_dataa,
  output logic [DATA_W-1:0] alu_datab,
  output logic [3:0]        alu_function,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0111;
  localparam logic [3:0] FN_NOR = 4'b0110;
  localparam logic [3:0] FN_SL  = 4'b1000;
  localparam logic [3:0] FN_SRL = 4'b1010;
  localparam logic [3:0] FN_SRA = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        fn_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] b_q;
  logic [4:0]        cnt_q;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q;

  logic       dec_legal, dec_shift, dec_var;
  logic [3:0] dec_fn;
  logic [4:0] shift_cnt;
  logic       accept;

  always_comb begin
    dec_legal = 1'b1;
    dec_shift = 1'b0;
    dec_var   = 1'b0;
    dec_fn    = FN_ADD;
    case (bus.req_funct)
      6'h20, 6'h21: dec_fn = FN_ADD;
      6'h22, 6'h23: dec_fn = FN_SUB;
      6'h24:        dec_fn = FN_AND;
      6'h25:        dec_fn = FN_OR;
      6'h26:        dec_fn = FN_XOR;
      6'h27:        dec_fn = FN_NOR;
      6'h00: begin dec_fn = FN_SL;  dec_shift = 1'b1; end
      6'h02: begin dec_fn = FN_SRL; dec_shift = 1'b1; end
      6'h03: begin dec_fn = FN_SRA; dec_shift = 1'b1; end
      6'h04: begin dec_fn = FN_SL;  dec_shift = 1'b1; dec_var = 1'b1; end
      6'h06: begin dec_fn = FN_SRL; dec_shift = 1'b1; dec_var = 1'b1; end
      6'h07: begin dec_fn = FN_SRA; dec_shift = 1'b1; dec_var = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign shift_cnt     = dec_var ? bus.req_a[4:0] : bus.req_shamt;
  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.rsp_result  = result_q;
  assign bus.rsp_illegal = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ALU inputs are forced to zero/ADD outside EXEC and SHIFT.
  always_comb begin
    state_d      = state_q;
    alu_dataa    = '0;
    alu_datab    = '0;
    alu_function = FN_ADD;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!dec_legal || (dec_shift && shift_cnt == 5'd0)) state_d = DONE;
          else if (dec_shift)                                 state_d = SHIFT;
          else                                                state_d = EXEC;
        end
      end
      EXEC: begin
        alu_dataa    = acc_q;
        alu_datab    = b_q;
        alu_function = fn_q;
        state_d      = DONE;
      end
      SHIFT: begin
        alu_dataa    = acc_q;
        alu_function = fn_q;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // acc holds rs for arith/logic ops and the running shifted value for shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_q      <= FN_ADD;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            fn_q      <= dec_fn;
            b_q       <= bus.req_b;
            acc_q     <= dec_shift ? bus.req_b : bus.req_a;
            cnt_q     <= dec_shift ? shift_cnt : 5'd0;
            illegal_q <= !dec_legal;
            result_q  <= (dec_shift && shift_cnt == 5'd0) ? bus.req_b : '0;
          end
        end
        EXEC: result_q <= alu_result;
        SHIFT: begin
          acc_q <= alu_result;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) result_q <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a scoreboard-driven response monitor.
module tb_alu_sequencer;
  logic        clk;
  logic        rst_n;
  logic [31:0] alu_dataa, alu_datab, alu_result;
  logic [3:0]  alu_function;

  alu_sequencer_if bus();

  alu_sequencer #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_dataa    (alu_dataa),
    .alu_datab    (alu_datab),
    .alu_function (alu_function),
    .alu_result   (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: shifts move by one bit per pass.
  always_comb begin
    alu_result = 32'h0;
    case (alu_function)
      4'b0000: alu_result = alu_dataa + alu_datab;
      4'b0010: alu_result = alu_dataa - alu_datab;
      4'b0100: alu_result = alu_dataa & alu_datab;
      4'b0101: alu_result = alu_dataa | alu_datab;
      4'b0111: alu_result = alu_dataa ^ alu_datab;
      4'b0110: alu_result = ~(alu_dataa | alu_datab);
      4'b1000: alu_result = alu_dataa << 1;
      4'b1010: alu_result = alu_dataa >> 1;
      4'b1001: alu_result = {alu_dataa[31], alu_dataa[31:1]};
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    logic        ill;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   ntot  = 0;
  int   npass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Response monitor: a handshake is completed at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_rsp: result %h illegal %b, expected no response",
                   bus.rsp_result, bus.rsp_illegal);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, bus.rsp_result, e.res);
          check({e.name, "_illegal"}, {31'h0, bus.rsp_illegal}, {31'h0, e.ill});
        end
      end
    end
  end

  task automatic do_op(input string name, input logic [5:0] funct, input logic [4:0] shamt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill,
                       input int exp_lat, input logic [3:0] exp_fn, input int hold);
    exp_t e;
    int   w, lat, fn_cnt;
    e.res = exp_res; e.ill = exp_ill; e.name = name;
    sb.push_back(e);
    bus.req_funct = funct; bus.req_shamt = shamt; bus.req_a = a; bus.req_b = b;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.req_ready) begin
      check({name, "_accept_timeout"}, {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1; fn_cnt = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 60) begin
      if (alu_function == exp_fn) fn_cnt++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_fn_cycles"}, fn_cnt, exp_lat - 1);
    check({name, "_alu_fn_done"}, {28'h0, alu_function}, 32'h0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check({name, "_hold_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        check({name, "_hold_result"}, bus.rsp_result, exp_res);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   {31'h0, bus.req_ready},   32'h0);
    check({tag, "_rsp_valid"},   {31'h0, bus.rsp_valid},   32'h0);
    check({tag, "_rsp_result"},  bus.rsp_result,           32'h0);
    check({tag, "_rsp_illegal"}, {31'h0, bus.rsp_illegal}, 32'h0);
    check({tag, "_alu_dataa"},   alu_dataa,                32'h0);
    check({tag, "_alu_datab"},   alu_datab,                32'h0);
    check({tag, "_alu_fn"},      {28'h0, alu_function},    32'h0);
  endtask

  task automatic abort_test();
    int w, saw;
    bus.rsp_ready = 1'b1;
    bus.req_funct = 6'h04; bus.req_shamt = 5'd0; bus.req_a = 32'h1F; bus.req_b = 32'h1;
    bus.req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    check("abort_accept", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1;
    end
    check("abort_no_rsp", saw, 0);
    check("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_funct = 6'h0; bus.req_shamt = 5'h0;
    bus.req_a = 32'h0; bus.req_b = 32'h0; bus.rsp_ready = 1'b0;
    #3 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;

    //     name     funct  shamt a             b             result        ill lat fn       hold
    do_op("add",    6'h20, 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 2, 4'b0000, 0);
    do_op("nor",    6'h27, 5'd0, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, 0, 2, 4'b0110, 5);
    do_op("sub",    6'h22, 5'd0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 2, 4'b0010, 5);
    do_op("sra4",   6'h03, 5'd4, 32'h00000000, 32'h80000010, 32'hF8000001, 0, 5, 4'b1001, 0);
    do_op("srlv3",  6'h06, 5'd0, 32'h00000023, 32'h80000000, 32'h10000000, 0, 4, 4'b1010, 0);
    do_op("sll0",   6'h00, 5'd0, 32'h00000000, 32'h12345678, 32'h12345678, 0, 1, 4'b1000, 0);
    do_op("illeg",  6'h18, 5'd3, 32'h11111111, 32'h22222222, 32'h00000000, 1, 1, 4'b0000, 0);
    do_op("and",    6'h24, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0, 2, 4'b0100, 0);
    do_op("or",     6'h25, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 0, 2, 4'b0101, 0);
    do_op("xor",    6'h26, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 2, 4'b0111, 0);
    do_op("addu",   6'h21, 5'd0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0, 2, 4'b0000, 0);
    do_op("subu",   6'h23, 5'd0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 2, 4'b0010, 0);
    do_op("sllv1",  6'h04, 5'd0, 32'h00000001, 32'h80000001, 32'h00000002, 0, 2, 4'b1000, 0);
    do_op("sllv0",  6'h04, 5'd7, 32'h00000020, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 4'b1000, 0);
    do_op("srav2",  6'h07, 5'd0, 32'hFFFFFFE2, 32'h40000000, 32'h10000000, 0, 3, 4'b1001, 0);
    do_op("srl31",  6'h02, 5'd31, 32'h0,       32'h80000000, 32'h00000001, 0, 32, 4'b1010, 0);

    abort_test();
    @(posedge clk); #1;
    do_op("add_post_abort", 6'h20, 5'd0, 32'h00000003, 32'h00000004, 32'h00000007, 0, 2, 4'b0000, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
